// File: rtl/reu_pkg.sv
// Shared REU definitions: transfer-type codes, sequencer states and the
// per-state bus/DRAM strobe pattern used by the transfer sequencer.
package reu_pkg;

  localparam logic [1:0] XT_STASH  = 2'b00;
  localparam logic [1:0] XT_FETCH  = 2'b01;
  localparam logic [1:0] XT_SWAP   = 2'b10;
  localparam logic [1:0] XT_VERIFY = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    START,
    XFER,
    SWAP_A,
    SWAP_B,
    DONE
  } state_t;

  typedef struct packed {
    logic caoe;
    logic cdoe;
    logic crw;
    logic ramrd;
    logic ramwr;
    logic latchc;
    logic latchr;
  } strb_t;

  // Ungated strobe pattern for a state; BA gating is applied at the outputs.
  function automatic strb_t strb_for(state_t st, logic [1:0] xt);
    strb_t s;
    s     = '0;
    s.crw = 1'b1;
    case (st)
      XFER: begin
        s.caoe = 1'b1;
        case (xt)
          XT_STASH:  s.ramwr = 1'b1;
          XT_FETCH: begin
            s.cdoe  = 1'b1;
            s.crw   = 1'b0;
            s.ramrd = 1'b1;
          end
          XT_VERIFY: s.ramrd = 1'b1;
          default: ;
        endcase
      end
      SWAP_A: begin
        s.caoe   = 1'b1;
        s.ramrd  = 1'b1;
        s.latchc = 1'b1;
        s.latchr = 1'b1;
      end
      SWAP_B: begin
        s.caoe  = 1'b1;
        s.cdoe  = 1'b1;
        s.crw   = 1'b0;
        s.ramwr = 1'b1;
      end
      default: ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/reu_xfer_ctl_if.sv
// Register-block / datapath side of the REU transfer sequencer.
// master = sequencer, slave = register block and datapath driving it.
interface reu_xfer_ctl_if;

  logic       Execute;
  logic [1:0] XferType;
  logic       Length1;
  logic       BA;
  logic       VerifyEq;

  logic DMAn;
  logic CRW;
  logic CAOE;
  logic CDOE;
  logic RAMRD;
  logic RAMWR;
  logic LatchC;
  logic LatchR;
  logic IncCA;
  logic IncREUA;
  logic DecLen;
  logic XferEnd;
  logic SetEndOfBlock;
  logic SetVerifyErr;
  logic Busy;

  modport master (
    input  Execute, XferType, Length1, BA, VerifyEq,
    output DMAn, CRW, CAOE, CDOE, RAMRD, RAMWR, LatchC, LatchR,
           IncCA, IncREUA, DecLen, XferEnd, SetEndOfBlock, SetVerifyErr, Busy
  );

  modport slave (
    output Execute, XferType, Length1, BA, VerifyEq,
    input  DMAn, CRW, CAOE, CDOE, RAMRD, RAMWR, LatchC, LatchR,
           IncCA, IncREUA, DecLen, XferEnd, SetEndOfBlock, SetVerifyErr, Busy
  );

endinterface

// File: rtl/reu_xfer_ctl.sv
// REU DMA transfer sequencer: takes the C64 bus on Execute and runs one
// stash/fetch/swap/verify transfer byte by byte, stalling while BA is low.
module reu_xfer_ctl (
  input  logic           PHI2,
  input  logic           nReset,
  reu_xfer_ctl_if.master bus
);
  import reu_pkg::*;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_xtype;
  logic [1:0] w_xtype_nxt;
  strb_t      r_strb;
  strb_t      w_strb_nxt;
  logic       r_busy;
  logic       r_byte;
  logic       r_vfy;
  logic       w_byte_done;
  logic       w_vfail;

  // A byte completes only in a byte-closing state while the VIC leaves the bus.
  assign w_byte_done = r_byte & bus.BA;
  assign w_vfail     = w_byte_done & r_vfy & ~bus.VerifyEq;

  always_comb begin
    w_state_nxt = r_state;
    w_xtype_nxt = r_xtype;
    case (r_state)
      IDLE: begin
        if (bus.Execute) begin
          w_state_nxt = START;
          w_xtype_nxt = bus.XferType;
        end
      end
      START: begin
        if (bus.BA) w_state_nxt = (r_xtype == XT_SWAP) ? SWAP_A : XFER;
      end
      XFER: begin
        if (w_byte_done && (bus.Length1 || w_vfail)) w_state_nxt = DONE;
      end
      SWAP_A: begin
        if (bus.BA) w_state_nxt = SWAP_B;
      end
      SWAP_B: begin
        if (bus.BA) w_state_nxt = bus.Length1 ? DONE : SWAP_A;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    w_strb_nxt = strb_for(w_state_nxt, w_xtype_nxt);
  end

  // Strobe pattern is registered for the state being entered.
  always_ff @(negedge PHI2) begin
    if (!nReset) begin
      r_state <= IDLE;
      r_xtype <= XT_STASH;
      r_strb  <= strb_for(IDLE, XT_STASH);
      r_busy  <= 1'b0;
      r_byte  <= 1'b0;
      r_vfy   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_xtype <= w_xtype_nxt;
      r_strb  <= w_strb_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_byte  <= (w_state_nxt == XFER) || (w_state_nxt == SWAP_B);
      r_vfy   <= (w_state_nxt == XFER) && (w_xtype_nxt == XT_VERIFY);
    end
  end

  assign bus.DMAn   = ~r_busy;
  assign bus.Busy   = r_busy;
  assign bus.CRW    = r_strb.crw | ~bus.BA;
  assign bus.CAOE   = r_strb.caoe & bus.BA;
  assign bus.CDOE   = r_strb.cdoe & bus.BA;
  assign bus.RAMRD  = r_strb.ramrd & bus.BA;
  assign bus.RAMWR  = r_strb.ramwr & bus.BA;
  assign bus.LatchC = r_strb.latchc & bus.BA;
  assign bus.LatchR = r_strb.latchr & bus.BA;

  assign bus.IncCA         = w_byte_done;
  assign bus.IncREUA       = w_byte_done;
  assign bus.DecLen        = w_byte_done;
  assign bus.XferEnd       = (w_byte_done & bus.Length1) | w_vfail;
  assign bus.SetEndOfBlock = w_byte_done & bus.Length1;
  assign bus.SetVerifyErr  = w_vfail;

endmodule
